// File: rtl/apb_completer_regs.sv
// APB3 completer with a word-addressed register bank, programmable wait states
// and PSLVERR on misaligned, out-of-range or read-only accesses.
//
// state    | meaning
// S_IDLE   | waiting for a setup cycle (psel && !penable)
// S_ACCESS | counting wait states, then presenting pready for one cycle
module apb_completer_regs #(
    parameter int              WIDTH       = 32,
    parameter int              ADDR_WIDTH  = 8,
    parameter int              NUM_REGS    = 16,
    parameter int              WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0]      pwdata,
    output logic [WIDTH-1:0]      prdata,
    output logic                  pready,
    output logic                  pslverr
);
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;
    logic             wr_q, wr_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic [WIDTH-1:0] prdata_q, prdata_d;
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    logic [IW-1:0]    setup_idx;
    logic             setup_err;

    assign setup_idx = paddr[ADDR_WIDTH-1:2];
    assign setup_err = (paddr[1:0] != 2'b00)
                    || (32'(setup_idx) >= NUM_REGS)
                    || (pwrite && (setup_idx == '0));

    // Register 0 is the constant ID; the stored slot 0 is never used.
    function automatic logic [WIDTH-1:0] read_val(input logic [IW-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        if (idx == '0) begin
            r = ID_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (32'(idx) == i) r = regs_q[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        wr_d      = wr_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        regs_d    = regs_q;

        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    cnt_d   = 4'(WAIT_STATES);
                    idx_d   = setup_idx;
                    err_d   = setup_err;
                    wr_d    = pwrite;
                    state_d = S_ACCESS;
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (!pwrite && !setup_err) ? read_val(setup_idx) : '0;
                    end
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q && penable) begin
                    if (wr_q && !err_q) begin
                        for (int i = 1; i < NUM_REGS; i++) begin
                            if (32'(idx_q) == i) regs_d[i] = pwdata;
                        end
                    end
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!wr_q && !err_q) ? read_val(idx_q) : '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: instance 0 uses one wait state, instance 1 none.
// Vector table, hand-written corner sequences, then random traffic vs. a register model.
module tb_apb_completer_regs;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        pclk = 1'b0;
    logic        presetn [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [2][16];

    always #5 pclk = ~pclk;

    apb_completer_regs #(.WAIT_STATES(1)) dut0 (
        .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_completer_regs #(.WAIT_STATES(0)) dut1 (
        .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    typedef struct {
        int          d;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // Starts #1 after a rising edge; ends #1 after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rd, output logic er,
                        output int lat, output logic after_rdy);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        lat = 1;
        while (pready[d] !== 1'b1 && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        rd = prdata[d];
        er = pslverr[d];
        @(posedge pclk); #1;
        after_rdy = pready[d];
        penable[d] = 1'b0;
        if (!hold) psel[d] = 1'b0;
    endtask

    // Reference behaviour straight from the access rules.
    function automatic logic model_err(input bit wr, input logic [7:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 16) || (wr && (a >> 2) == 0);
    endfunction

    function automatic logic [31:0] model_rd(input int d, input bit wr, input logic [7:0] a);
        int idx;
        idx = int'(a >> 2);
        if (wr || model_err(wr, a)) return 32'h0;
        return (idx == 0) ? ID : mdl[d][idx];
    endfunction

    task automatic model_commit(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd);
        if (wr && !model_err(wr, a)) mdl[d][int'(a >> 2)] = wd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, ar;
        int          lat;
        logic [7:0]  a;
        logic [31:0] wd;
        bit          wr;
        int          d;

        for (int k = 0; k < 2; k++) begin
            presetn[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0;
            pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
            for (int i = 0; i < 16; i++) mdl[k][i] = '0;
        end

        vt[0]  = '{0, 1'b0, 8'h00, 32'h0,         ID,            1'b0};
        vt[1]  = '{0, 1'b0, 8'h04, 32'h0,         32'h0,         1'b0};
        vt[2]  = '{0, 1'b1, 8'h08, 32'hDEADBEEF,  32'h0,         1'b0};
        vt[3]  = '{0, 1'b0, 8'h08, 32'h0,         32'hDEADBEEF,  1'b0};
        vt[4]  = '{0, 1'b1, 8'h00, 32'h12345678,  32'h0,         1'b1};
        vt[5]  = '{0, 1'b0, 8'h00, 32'h0,         ID,            1'b0};
        vt[6]  = '{0, 1'b0, 8'h06, 32'h0,         32'h0,         1'b1};
        vt[7]  = '{0, 1'b0, 8'h40, 32'h0,         32'h0,         1'b1};
        vt[8]  = '{0, 1'b1, 8'h40, 32'h77777777,  32'h0,         1'b1};
        vt[9]  = '{0, 1'b0, 8'h3C, 32'h0,         32'h0,         1'b0};
        vt[10] = '{1, 1'b0, 8'h00, 32'h0,         ID,            1'b0};
        vt[11] = '{1, 1'b1, 8'h3C, 32'h0BADF00D,  32'h0,         1'b0};
        vt[12] = '{1, 1'b0, 8'h3C, 32'h0,         32'h0BADF00D,  1'b0};
        vt[13] = '{0, 1'b1, 8'h05, 32'h99999999,  32'h0,         1'b1};
        vt[14] = '{0, 1'b0, 8'h04, 32'h0,         32'h0,         1'b0};

        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_pready%0d", k), 32'(pready[k]), 32'h0);
            chk($sformatf("reset_pslverr%0d", k), 32'(pslverr[k]), 32'h0);
            chk($sformatf("reset_prdata%0d", k), prdata[k], 32'h0);
        end
        presetn[0] = 1'b1; presetn[1] = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 15; i++) begin
            xfer(vt[i].d, vt[i].wr, vt[i].a, vt[i].wd, 1'b0, rd, er, lat, ar);
            chk($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), (vt[i].d == 0) ? 32'd2 : 32'd1);
            chk($sformatf("vec%0d_pready_drop", i), 32'(ar), 32'h0);
            model_commit(vt[i].d, vt[i].wr, vt[i].a, vt[i].wd);
        end

        // Back-to-back with no wait states and psel held high throughout.
        for (int x = 4; x <= 60; x += 4) begin
            a = 8'(x);
            xfer(1, 1'b1, a, 32'(x), 1'b1, rd, er, lat, ar);
            chk($sformatf("b2b_wr%0d_latency", x), 32'(lat), 32'd1);
            model_commit(1, 1'b1, a, 32'(x));
            xfer(1, 1'b0, a, 32'h0, (x != 60), rd, er, lat, ar);
            chk($sformatf("b2b_rd%0d_latency", x), 32'(lat), 32'd1);
            chk($sformatf("b2b_rd%0d_prdata", x), rd, 32'(x));
            chk($sformatf("b2b_rd%0d_pslverr", x), 32'(er), 32'h0);
        end

        // Abort: psel dropped during the wait state of a write.
        xfer(0, 1'b1, 8'h10, 32'h11112222, 1'b0, rd, er, lat, ar);
        model_commit(0, 1'b1, 8'h10, 32'h11112222);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h10; pwdata[0] = 32'h5555AAAA;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        chk("abort_wait_pready", 32'(pready[0]), 32'h0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge pclk); #1;
            chk($sformatf("abort_pready_c%0d", c), 32'(pready[0]), 32'h0);
        end
        xfer(0, 1'b0, 8'h10, 32'h0, 1'b0, rd, er, lat, ar);
        chk("abort_readback", rd, 32'h11112222);

        // penable without a preceding setup cycle is ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'h08;
        for (int c = 0; c < 3; c++) begin
            @(posedge pclk); #1;
            chk($sformatf("nosetup_pready_c%0d", c), 32'(pready[0]), 32'h0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge pclk); #1;

        // Reset asserted while a write to 0x0C is presenting pready.
        xfer(0, 1'b1, 8'h0C, 32'h0000ABCD, 1'b0, rd, er, lat, ar);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h0C; pwdata[0] = 32'hCAFEF00D;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        @(posedge pclk); #1;
        chk("rst_mid_pready_before", 32'(pready[0]), 32'h1);
        presetn[0] = 1'b0;
        #1;
        chk("rst_mid_pready_after", 32'(pready[0]), 32'h0);
        chk("rst_mid_pslverr_after", 32'(pslverr[0]), 32'h0);
        chk("rst_mid_prdata_after", prdata[0], 32'h0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        for (int i = 0; i < 16; i++) mdl[0][i] = '0;
        @(posedge pclk); #1;
        presetn[0] = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'h0C, 32'h0, 1'b0, rd, er, lat, ar);
        chk("rst_mid_readback", rd, 32'h0);
        xfer(0, 1'b0, 8'h10, 32'h0, 1'b0, rd, er, lat, ar);
        chk("rst_mid_readback_other", rd, 32'h0);

        // Random traffic on both instances against the register model.
        for (int n = 0; n < 120; n++) begin
            d  = n % 2;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 9))
                7:       a = 8'($urandom_range(16, 63) << 2);
                8:       a = 8'(($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
                9:       a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(0, 15) << 2);
            endcase
            xfer(d, wr, a, wd, 1'b0, rd, er, lat, ar);
            chk($sformatf("rnd%0d_prdata a=%02h w=%0d", n, a, wr), rd, model_rd(d, wr, a));
            chk($sformatf("rnd%0d_pslverr a=%02h w=%0d", n, a, wr), 32'(er), 32'(model_err(wr, a)));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), (d == 0) ? 32'd2 : 32'd1);
            model_commit(d, wr, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
